ring_digit_scanner: RTL and testbench
=====================================

# ring_digit_scanner

Downstream consumer of the 4-bit one-hot ring counter. Uses the ring state as the digit-scan strobe for a 4-digit multiplexed seven-segment display. Checks that the ring sequence is legal, counts complete revolutions, and commits new display data only at revolution boundaries so a digit never tears mid-scan. Sits between the ring counter outputs and the board display pins.

## Interface
- SEG_ACTIVE_LOW, 1, when 1 the seg outputs are inverted (0 = segment lit).
- REV_WIDTH, 8, width of the revolution counter.

- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- ring  input  4  one-hot ring state; legal order 0001→0010→0100→1000→0001.
- data  input  16  display word; digit i shows data[4i+3:4i].
- data_load  input  1  capture data into the staging register this cycle.
- err_clr  input  1  clear the sticky error and leave FAULT.
- an  output  4  digit enables, active-high, one-hot or all-zero.
- seg  output  7  segments gfedcba for the selected digit.
- rev_count  output  REV_WIDTH  completed revolutions, wraps modulo 2^REV_WIDTH.
- ring_err  output  1  sticky illegal-ring flag.

## Operation
- Input stage: ring is registered into ring_q each cycle. prev_q holds the previous ring_q.
- Staging: on data_load, stage_q <= data and pend_q <= 1. If data_load repeats before commit, the latest value wins.
- Commit: happens when ring_q == 0001 and prev_q != 0001 in RUN, or on the SYNC→RUN transition.
  - If pend_q = 1, disp_q <= stage_q and pend_q <= 0.
  - If data_load coincides with a commit, the incoming data is staged and commits at the next boundary.
- FSM states: SYNC, RUN, FAULT.
  - SYNC: an = 0, seg blank. ring_q values other than 0001, including 0000, are not errors. Go to RUN when ring_q == 0001.
  - RUN:
    - ring_q == prev_q is a legal hold.
    - ring_q == rotate-left(prev_q) is a legal advance.
    - Anything else (not one-hot, or a skip/reverse) goes to FAULT and sets ring_err.
  - FAULT: an = 0, seg blank, no error evaluation. err_clr goes to SYNC and clears ring_err in the same edge.
- err_clr in SYNC or RUN clears ring_err only. In RUN, if err_clr coincides with a new error, the error wins and ring_err stays 1.
- Revolution count: rev_count increments by 1 when in RUN with prev_q == 1000 and ring_q == 0001 (legal advance). Holds on 0001 do not count. The SYNC→RUN entry does not count.
- Display in RUN:
  - an <= ring_q.
  - seg <= hex7seg(nibble selected by ring_q). Nibble source is disp_q, or the value being committed this edge, so digit 0 of a new revolution shows new data.
- hex7seg (gfedcba, active-high): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71. When SEG_ACTIVE_LOW = 1, the output is inverted.
- Blank means all segments off: 7F if SEG_ACTIVE_LOW, else 00.

## Timing
- Reset (asynchronous assert, synchronous release) gives:
  - ring_q = 0, prev_q = 0, state SYNC
  - an = 0, seg = blank
  - rev_count = 0, ring_err = 0
  - stage_q = 0, disp_q = 0, pend_q = 0
- Latency: a ring value present before edge N lands in ring_q at edge N. The FSM, an, seg, rev_count and ring_err reflect it at edge N+1, i.e. 2 cycles from ring to an.
- ring_err and the FAULT blanking take effect on the same edge N+1. an is 0 from that edge on.
- data_load at edge M is visible on seg no earlier than the next commit edge after M.
- Reset mid-operation discards staged data, count and error immediately.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then ring 0000 for 5 cycles → state SYNC, an = 0, seg = 7F, ring_err = 0, rev_count = 0.
- data = 16'h1234 with data_load, then ring cycles 0001,0010,0100,1000,0001 one per clock (SEG_ACTIVE_LOW = 0):
  - 2 cycles after each ring value, an = 0001/0010/0100/1000 with seg = 66/4F/5B/06.
  - rev_count = 1 after the second 0001.
- While scanning 16'h1234, load 16'hABCD when ring = 0010 → digits 1–3 still show 3,2,1; the next 0001 shows D (5E), then C, b, A.
- Ring 0001,0010,1000 (skip) → ring_err = 1 and an = 0 two cycles after 1000. A further ring 0011 keeps FAULT. err_clr → SYNC, ring_err = 0. The next 0001 → RUN.
- 256 full revolutions with REV_WIDTH = 8 → rev_count wraps to 0. Ring held at 0100 for 10 cycles → no error, count unchanged.
- Assert reset low mid-scan with a pending load → all outputs at reset values on the same cycle. After release, the pending data is never displayed; disp_q = 0000.

Source files
------------

// File: rtl/ring_digit_scanner.sv
// Seven-segment digit scanner driven by a 4-bit one-hot ring counter.
// Validates the ring sequence, counts revolutions and swaps display data only at revolution boundaries.
module ring_digit_scanner #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int REV_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           ring,
  input  logic [15:0]          data,
  input  logic                 data_load,
  input  logic                 err_clr,
  output logic [3:0]           an,
  output logic [6:0]           seg,
  output logic [REV_WIDTH-1:0] rev_count,
  output logic                 ring_err
);

  typedef enum logic [1:0] {SYNC, RUN, FAULT} state_t;

  localparam logic [6:0] BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [REV_WIDTH-1:0] REV_ONE = {{(REV_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  state_t      state;
  logic [3:0]  ring_q, prev_q;
  logic [15:0] stage_q, disp_q;
  logic        pend_q;

  logic        at_zero, legal, commit, wrap, next_run;
  logic [15:0] disp_nx;
  logic [3:0]  nib;
  logic [6:0]  seg_lit;

  always_comb begin
    at_zero  = (ring_q == 4'b0001);
    legal    = $onehot(ring_q) &&
               ((ring_q == prev_q) || (ring_q == {prev_q[2:0], prev_q[3]}));
    commit   = at_zero && ((state == SYNC) || ((state == RUN) && (prev_q != 4'b0001)));
    wrap     = (state == RUN) && legal && (prev_q == 4'b1000) && at_zero;
    next_run = ((state == SYNC) && at_zero) || ((state == RUN) && legal);
    // Use the value being committed so digit 0 of a new revolution already shows it
    disp_nx  = (commit && pend_q) ? stage_q : disp_q;
    case (ring_q)
      4'b0010: nib = disp_nx[7:4];
      4'b0100: nib = disp_nx[11:8];
      4'b1000: nib = disp_nx[15:12];
      default: nib = disp_nx[3:0];
    endcase
    seg_lit  = hex7(nib);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SYNC;
      ring_q    <= 4'b0000;
      prev_q    <= 4'b0000;
      stage_q   <= 16'h0000;
      disp_q    <= 16'h0000;
      pend_q    <= 1'b0;
      an        <= 4'b0000;
      seg       <= BLANK;
      rev_count <= '0;
      ring_err  <= 1'b0;
    end else begin
      ring_q <= ring;
      prev_q <= ring_q;
      disp_q <= disp_nx;

      if (data_load) begin
        stage_q <= data;
        pend_q  <= 1'b1;
      end else if (commit) begin
        pend_q  <= 1'b0;
      end

      if (next_run) begin
        an  <= ring_q;
        seg <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
      end else begin
        an  <= 4'b0000;
        seg <= BLANK;
      end

      if (wrap) rev_count <= rev_count + REV_ONE;

      case (state)
        SYNC: begin
          if (at_zero) state <= RUN;
          if (err_clr) ring_err <= 1'b0;
        end
        RUN: begin
          // A new error takes priority over a simultaneous clear
          if (!legal) begin
            state    <= FAULT;
            ring_err <= 1'b1;
          end else if (err_clr) begin
            ring_err <= 1'b0;
          end
        end
        default: begin
          if (err_clr) begin
            state    <= SYNC;
            ring_err <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_digit_scanner.sv
// Directed + random bench for ring_digit_scanner; two instances cover both segment polarities.
module tb_ring_digit_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  ring = 4'b0000;
  logic [15:0] data = 16'h0000;
  logic        data_load = 1'b0;
  logic        err_clr = 1'b0;
  logic [3:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic [7:0]  rev0, rev1;
  logic        err0, err1;

  int n_cmp = 0;
  int n_fail = 0;

  ring_digit_scanner #(.SEG_ACTIVE_LOW(1'b0), .REV_WIDTH(8)) u_hi (
    .clk(clk), .reset(reset), .ring(ring), .data(data), .data_load(data_load),
    .err_clr(err_clr), .an(an0), .seg(seg0), .rev_count(rev0), .ring_err(err0));
  ring_digit_scanner #(.SEG_ACTIVE_LOW(1'b1), .REV_WIDTH(8)) u_lo (
    .clk(clk), .reset(reset), .ring(ring), .data(data), .data_load(data_load),
    .err_clr(err_clr), .an(an1), .seg(seg1), .rev_count(rev1), .ring_err(err1));

  always #5 clk = ~clk;

  // Reference model: mode 0 = waiting for digit 0, 1 = scanning, 2 = faulted
  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          m_mode, m_rev;
  logic [3:0]  m_rq, m_pq, m_an;
  logic [15:0] m_stage, m_disp;
  bit          m_pend, m_err;
  logic [6:0]  m_seg;   // lit pattern, 0 when blank

  function automatic int pos(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_rev = 0; m_rq = 0; m_pq = 0; m_an = 0;
    m_stage = 0; m_disp = 0; m_pend = 0; m_err = 0; m_seg = 0;
  endtask

  task automatic model_step();
    int pi, ri, nmode;
    bit commit, ok;
    logic [15:0] shown;
    if (!reset) begin model_reset(); return; end
    pi = pos(m_pq); ri = pos(m_rq);
    commit = (ri == 0) && (m_mode == 0 || (m_mode == 1 && pi != 0));
    nmode = m_mode;
    if (m_mode == 0) begin
      if (ri == 0) nmode = 1;
      if (err_clr) m_err = 0;
    end else if (m_mode == 1) begin
      ok = (ri >= 0) && (ri == pi || ri == (pi + 1) % 4);
      if (!ok) begin nmode = 2; m_err = 1; end
      else begin
        if (err_clr) m_err = 0;
        if (pi == 3 && ri == 0) m_rev = (m_rev + 1) % 256;
      end
    end else if (err_clr) begin
      nmode = 0; m_err = 0;
    end
    shown = (commit && m_pend) ? m_stage : m_disp;
    if (nmode == 1) begin
      m_an = m_rq;
      m_seg = font[(shown >> (4 * ri)) & 16'hF];
    end else begin
      m_an = 0; m_seg = 0;
    end
    m_disp = shown;
    if (data_load) begin m_stage = data; m_pend = 1; end
    else if (commit) m_pend = 0;
    m_mode = nmode;
    m_pq = m_rq;
    m_rq = ring;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("an_hi", {28'd0, an0}, {28'd0, m_an});
    chk("an_lo", {28'd0, an1}, {28'd0, m_an});
    chk("seg_hi", {25'd0, seg0}, {25'd0, m_seg});
    chk("seg_lo", {25'd0, seg1}, {25'd0, ~m_seg});
    chk("rev_hi", {24'd0, rev0}, m_rev);
    chk("rev_lo", {24'd0, rev1}, m_rev);
    chk("err_hi", {31'd0, err0}, {31'd0, m_err});
    chk("err_lo", {31'd0, err1}, {31'd0, m_err});
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic [3:0] r);
    ring = r;
    cyc();
  endtask

  task automatic disp_chk(input string tag, input logic [3:0] a, input logic [6:0] s);
    chk({tag, "_an"}, {28'd0, an0}, {28'd0, a});
    chk({tag, "_seg"}, {25'd0, seg0}, {25'd0, s});
  endtask

  initial begin
    int rsave;
    logic [3:0] cur;
    model_reset();
    #12 reset = 1'b1;

    // Idle ring after reset
    for (int i = 0; i < 5; i++) drive(4'b0000);
    chk("idle_seg_lo", {25'd0, seg1}, 32'h7F);
    chk("idle_an", {28'd0, an1}, 32'h0);

    // First revolution of 1234
    data = 16'h1234; data_load = 1'b1; drive(4'b0001);
    data_load = 1'b0;
    drive(4'b0010); disp_chk("d0", 4'b0001, 7'h66);
    drive(4'b0100); disp_chk("d1", 4'b0010, 7'h4F);
    drive(4'b1000); disp_chk("d2", 4'b0100, 7'h5B);
    drive(4'b0001); disp_chk("d3", 4'b1000, 7'h06);
    drive(4'b0010); disp_chk("d0b", 4'b0001, 7'h66);
    chk("rev_first", {24'd0, rev0}, 32'd1);

    // Mid-scan load waits for the next boundary
    data = 16'hABCD; data_load = 1'b1; drive(4'b0100); disp_chk("m1", 4'b0010, 7'h4F);
    data_load = 1'b0;
    drive(4'b1000); disp_chk("m2", 4'b0100, 7'h5B);
    drive(4'b0001); disp_chk("m3", 4'b1000, 7'h06);
    drive(4'b0010); disp_chk("n0", 4'b0001, 7'h5E);
    drive(4'b0100); disp_chk("n1", 4'b0010, 7'h39);
    drive(4'b1000); disp_chk("n2", 4'b0100, 7'h7C);
    drive(4'b0001); disp_chk("n3", 4'b1000, 7'h77);

    // Skip -> fault, clear, resync
    drive(4'b0010);
    drive(4'b1000);
    drive(4'b0011);
    chk("skip_err", {31'd0, err0}, 32'd1);
    chk("skip_an", {28'd0, an0}, 32'd0);
    drive(4'b0011);
    chk("fault_hold", {31'd0, err0}, 32'd1);
    err_clr = 1'b1; drive(4'b0011); err_clr = 1'b0;
    chk("clr_err", {31'd0, err0}, 32'd0);
    drive(4'b0001);
    drive(4'b0010); disp_chk("resync", 4'b0001, 7'h5E);

    // 256 revolutions wrap the counter
    rsave = rev0;
    for (int r = 0; r < 256; r++) begin
      drive(4'b0100); drive(4'b1000); drive(4'b0001); drive(4'b0010);
    end
    chk("rev_wrap", {24'd0, rev0}, rsave);
    drive(4'b0100);
    for (int i = 0; i < 10; i++) drive(4'b0100);
    chk("hold_err", {31'd0, err0}, 32'd0);
    chk("hold_rev", {24'd0, rev0}, rsave);

    // Random ring walks with occasional glitches, loads and clears
    cur = 4'b0100;
    for (int i = 0; i < 2000; i++) begin
      int p;
      p = $urandom_range(99);
      if (p < 78) cur = (cur == 4'b0000) ? 4'b0001 : {cur[2:0], cur[3]};
      else if (p < 92) cur = cur;
      else cur = 4'($urandom_range(15));
      data = 16'($urandom);
      data_load = ($urandom_range(9) == 0);
      err_clr = ($urandom_range(19) == 0);
      drive(cur);
    end
    data_load = 1'b0; err_clr = 1'b0;

    // Reset mid-scan with a pending load
    err_clr = 1'b1; drive(4'b0000); err_clr = 1'b0;
    drive(4'b0001); drive(4'b0010); drive(4'b0100);
    data = 16'h5678; data_load = 1'b1; drive(4'b1000); data_load = 1'b0;
    #3 reset = 1'b0;
    #1 model_reset();
    check_model();
    chk("rst_an", {28'd0, an0}, 32'd0);
    chk("rst_seg_lo", {25'd0, seg1}, 32'h7F);
    chk("rst_rev", {24'd0, rev0}, 32'd0);
    drive(4'b0001);
    reset = 1'b1;
    drive(4'b0001);
    drive(4'b0010); disp_chk("post_rst0", 4'b0001, 7'h3F);
    drive(4'b0100); disp_chk("post_rst1", 4'b0010, 7'h3F);
    drive(4'b1000);
    drive(4'b0001); disp_chk("post_rst3", 4'b1000, 7'h3F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
